mc_bus_feeder: RTL

- Upstream stage of the global PE array. Drives the shared multicast bus that each PE's multicaster snoops.
- Accepts a stream of operand words from the global buffer. Buffers them in a small FIFO.
- Tags each word with a (row, col) destination ID in raster order, then presents it on the bus with a valid/ready handshake.
- Counts one tile of words per start command and pulses done when the last word has been consumed by the bus.

---
 rtl/mc_bus_feeder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mc_bus_feeder.sv
// Multicast bus feeder: buffers operand words, tags them with raster (row, col) IDs and drives the PE bus.
// Optional macro MC_BUS_PARITY_EN adds a stored parity bit output (bus_parity).
module mc_bus_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int NUM_ROW    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_WIDTH  = 16,
    localparam int COL_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
    localparam int ROW_W = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  tile_len,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic [ROW_W-1:0]      bus_row_id,
    output logic [COL_W-1:0]      bus_col_id,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic                  busy,
`ifdef MC_BUS_PARITY_EN
    output logic                  bus_parity,
`endif
    output logic                  done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef MC_BUS_PARITY_EN
    localparam int ENTRY_W = DATA_WIDTH + COL_W + ROW_W + 1;
`else
    localparam int ENTRY_W = DATA_WIDTH + COL_W + ROW_W;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q, in_cnt, out_cnt;
    logic [COL_W-1:0]     col_tag;
    logic [ROW_W-1:0]     row_tag;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_next;
    logic [CNT_W-1:0]     count, cnt_after_pop, count_next;
    logic                 fifo_full, push, pop, head_load;
    logic [ENTRY_W-1:0]   push_entry, head_entry;

    always_comb begin
        fifo_full     = (count == CNT_W'(FIFO_DEPTH));
        in_ready      = (state == RUN) && !fifo_full && (in_cnt < len_q);
        push          = in_valid && in_ready;
        pop           = bus_valid && bus_ready;
`ifdef MC_BUS_PARITY_EN
        push_entry    = {^{in_data, row_tag, col_tag}, row_tag, col_tag, in_data};
`else
        push_entry    = {row_tag, col_tag, in_data};
`endif
        rd_next       = rd_ptr + PTR_W'(pop);
        cnt_after_pop = count - CNT_W'(pop);
        count_next    = cnt_after_pop + CNT_W'(push);
        // The bus register always mirrors the FIFO head; a word arriving into an
        // emptied FIFO becomes the head directly.
        head_entry    = (cnt_after_pop == '0) ? push_entry : mem[rd_next];
        head_load     = push || (cnt_after_pop != '0);
    end

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len_q      <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            col_tag    <= '0;
            row_tag    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            bus_valid  <= 1'b0;
            bus_data   <= '0;
            bus_row_id <= '0;
            bus_col_id <= '0;
`ifdef MC_BUS_PARITY_EN
            bus_parity <= 1'b0;
`endif
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done      <= 1'b0;
            count     <= count_next;
            bus_valid <= (count_next != '0);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                in_cnt <= in_cnt + LEN_WIDTH'(1);
                if (col_tag == COL_W'(NUM_COL - 1)) begin
                    col_tag <= '0;
                    row_tag <= (row_tag == ROW_W'(NUM_ROW - 1)) ? '0 : row_tag + ROW_W'(1);
                end else begin
                    col_tag <= col_tag + COL_W'(1);
                end
            end
            if (pop) begin
                rd_ptr  <= rd_next;
                out_cnt <= out_cnt + LEN_WIDTH'(1);
            end
            if (head_load) begin
                bus_data   <= head_entry[DATA_WIDTH-1:0];
                bus_col_id <= head_entry[DATA_WIDTH +: COL_W];
                bus_row_id <= head_entry[DATA_WIDTH+COL_W +: ROW_W];
`ifdef MC_BUS_PARITY_EN
                bus_parity <= head_entry[ENTRY_W-1];
`endif
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (tile_len != '0) begin
                            len_q   <= tile_len;
                            in_cnt  <= '0;
                            out_cnt <= '0;
                            col_tag <= '0;
                            row_tag <= '0;
                            state   <= RUN;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop && (out_cnt + LEN_WIDTH'(1) == len_q)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
